// File: rtl/hello_pkg.sv
// Shared constants for the HELLO scroller: character codes, message ROM and FSM states.
package hello_pkg;

    localparam int unsigned MSG_LEN = 8;
    localparam int unsigned PTR_W   = $clog2(MSG_LEN);

    localparam logic [2:0] CODE_H     = 3'd0;
    localparam logic [2:0] CODE_E     = 3'd1;
    localparam logic [2:0] CODE_L     = 3'd2;
    localparam logic [2:0] CODE_O     = 3'd3;
    localparam logic [2:0] CODE_BLANK = 3'd4;

    // Element 0 is the first message character, so the concatenation reads backwards.
    localparam logic [MSG_LEN-1:0][2:0] MSG_ROM = {
        CODE_BLANK, CODE_BLANK, CODE_BLANK, CODE_O, CODE_L, CODE_L, CODE_E, CODE_H
    };

    typedef enum logic {S_STOP, S_RUN} scroll_state_t;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..TICKS-1 while enabled and flags the last count of each period.
module tick_gen #(
    parameter int unsigned TICKS = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = $clog2(TICKS + 1);
    localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = en && (count_q == LAST);

endmodule

// File: rtl/hello_scroller.sv
// Scrolls "HELLO___" across NUM_DISP HELO digit decoders, automatically or by manual step.
module hello_scroller
    import hello_pkg::*;
#(
    parameter int unsigned TICKS    = 25_000_000,
    parameter int unsigned NUM_DISP = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    input  logic                    step,
    input  logic                    dir,
    output logic [3*NUM_DISP-1:0]   codes,
    output logic [PTR_W-1:0]        ptr,
    output logic                    adv
);

    scroll_state_t    state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             adv_q, adv_d;
    logic             running, tg_en, tick, advance;

    assign running = (state_q == S_RUN);
    // Dropping run clears the prescaler in the same cycle, so a restart counts a full period.
    assign tg_en   = running && run;

    tick_gen #(
        .TICKS (TICKS)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (!tg_en),
        .en   (tg_en),
        .tick (tick)
    );

    assign advance = tick || (!running && !run && step);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_STOP:  if (run)  state_d = S_RUN;
            S_RUN:   if (!run) state_d = S_STOP;
            default: state_d = S_STOP;
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = dir ? ptr_q - PTR_W'(1) : ptr_q + PTR_W'(1);
        end
        adv_d = advance;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_STOP;
            ptr_q   <= '0;
            adv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            adv_q   <= adv_d;
        end
    end

    assign ptr = ptr_q;
    assign adv = adv_q;

    // Highest digit is leftmost and shows the message character at ptr.
    for (genvar i = 0; i < NUM_DISP; i++) begin : g_codes
        logic [PTR_W-1:0] idx;
        assign idx              = ptr_q + PTR_W'(NUM_DISP - 1 - i);
        assign codes[3*i +: 3] = MSG_ROM[idx];
    end

endmodule

// File: tb/tb_hello_scroller.sv
// Bench for hello_scroller: TICKS=4 and TICKS=1 instances checked against a cycle-level model.
module tb_hello_scroller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        dir = 1'b0;
    logic [17:0] codes0, codes1;
    logic [2:0]  ptr0, ptr1;
    logic        adv0, adv1;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    localparam logic [17:0] RESET_CODES = {3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4};
    localparam logic [17:0] P1_CODES    = {3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd4};
    localparam logic [17:0] P7_CODES    = {3'd4, 3'd0, 3'd1, 3'd2, 3'd2, 3'd3};

    hello_scroller #(.TICKS(4), .NUM_DISP(6)) dut0 (
        .clk(clk), .rst(rst), .run(run), .step(step), .dir(dir),
        .codes(codes0), .ptr(ptr0), .adv(adv0)
    );

    hello_scroller #(.TICKS(1), .NUM_DISP(6)) dut1 (
        .clk(clk), .rst(rst), .run(run), .step(step), .dir(dir),
        .codes(codes1), .ptr(ptr1), .adv(adv1)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] char_code(byte ch);
        case (ch)
            "H":     return 3'd0;
            "E":     return 3'd1;
            "L":     return 3'd2;
            "O":     return 3'd3;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [17:0] exp_codes(int p);
        string       msg = "HELLO___";
        logic [17:0] r   = '0;
        for (int i = 0; i < 6; i++) r[3*i +: 3] = char_code(msg[(p + 5 - i) % 8]);
        return r;
    endfunction

    function automatic int ticks_of(int k);
        return (k == 0) ? 4 : 1;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Model: "running" plus cycles elapsed since entering run; advance every ticks_of(k) cycles.
    int ptr_m [2];
    int el_m  [2];
    bit run_m [2];
    bit adv_m [2];

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                ptr_m[k] <= 0;
                el_m[k]  <= 0;
                run_m[k] <= 1'b0;
                adv_m[k] <= 1'b0;
            end else begin
                adv_m[k] <= 1'b0;
                if (!run_m[k]) begin
                    if (run) begin
                        run_m[k] <= 1'b1;
                        el_m[k]  <= 0;
                    end else if (step) begin
                        ptr_m[k] <= dir ? (ptr_m[k] + 7) % 8 : (ptr_m[k] + 1) % 8;
                        adv_m[k] <= 1'b1;
                    end
                end else if (!run) begin
                    run_m[k] <= 1'b0;
                end else begin
                    el_m[k] <= el_m[k] + 1;
                    if ((el_m[k] + 1) % ticks_of(k) == 0) begin
                        ptr_m[k] <= dir ? (ptr_m[k] + 7) % 8 : (ptr_m[k] + 1) % 8;
                        adv_m[k] <= 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("ptr_t4",   32'(ptr0),   32'(ptr_m[0]));
            check("adv_t4",   32'(adv0),   32'(adv_m[0]));
            check("codes_t4", 32'(codes0), 32'(exp_codes(ptr_m[0])));
            check("ptr_t1",   32'(ptr1),   32'(ptr_m[1]));
            check("adv_t1",   32'(adv1),   32'(adv_m[1]));
            check("codes_t1", 32'(codes1), 32'(exp_codes(ptr_m[1])));
        end
    end

    task automatic cycles(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        #3 rst = 1'b0;
        #1;
    endtask

    initial begin
        #1 rst = 1'b1;
        #1 cmp_en = 1'b1;
        #10 rst = 1'b0;

        // Reset state held while idle
        cycles(3);
        check("lit_reset_ptr",   32'(ptr0),   32'd0);
        check("lit_reset_adv",   32'(adv0),   32'd0);
        check("lit_reset_codes", 32'(codes0), 32'(RESET_CODES));

        // Automatic scroll left: entry edge plus four more for the first advance
        run = 1'b1;
        cycles(5);
        check("lit_run_ptr1",   32'(ptr0),   32'd1);
        check("lit_run_adv",    32'(adv0),   32'd1);
        check("lit_run_codes1", 32'(codes0), 32'(P1_CODES));
        cycles(1);
        check("lit_adv_one_cycle", 32'(adv0), 32'd0);
        cycles(27);
        check("lit_wrap_ptr",   32'(ptr0),   32'd0);
        check("lit_wrap_codes", 32'(codes0), 32'(RESET_CODES));

        // Manual step right from reset wraps 0 -> 7
        run = 1'b0;
        pulse_reset();
        dir  = 1'b1;
        step = 1'b1;
        cycles(1);
        step = 1'b0;
        cycles(1);
        check("lit_step_ptr7",   32'(ptr0),   32'd7);
        check("lit_step_codes7", 32'(codes0), 32'(P7_CODES));
        step = 1'b1;
        run  = 1'b1;
        cycles(1);
        step = 1'b0;
        cycles(1);
        check("lit_step_with_run", 32'(ptr0), 32'd7);
        run = 1'b0;
        cycles(2);

        // Run dropped at prescaler=3: no advance, restart needs a full period
        dir = 1'b0;
        pulse_reset();
        run = 1'b1;
        cycles(4);
        check("lit_t1_ptr", 32'(ptr1), 32'd3);
        run = 1'b0;
        cycles(1);
        check("lit_drop_no_adv", 32'(ptr0), 32'd0);
        run = 1'b1;
        cycles(4);
        check("lit_restart_wait", 32'(ptr0), 32'd0);
        cycles(1);
        check("lit_restart_adv", 32'(ptr0), 32'd1);
        cycles(6);

        // Asynchronous reset between edges mid-run
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("lit_async_ptr",   32'(ptr0),   32'd0);
        check("lit_async_adv",   32'(adv0),   32'd0);
        check("lit_async_codes", 32'(codes0), 32'(RESET_CODES));
        #2 rst = 1'b0;
        cycles(4);
        check("lit_post_reset_wait", 32'(ptr0), 32'd0);
        cycles(1);
        check("lit_post_reset_adv", 32'(ptr0), 32'd1);

        // Randomized phase; the negedge compare process checks every cycle
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 7) == 0) run = ~run;
            step = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) dir = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 149) == 0) begin
                #2 rst = 1'b1;
                #2 rst = 1'b0;
            end
            cycles(1);
        end

        run  = 1'b0;
        step = 1'b0;
        cycles(2);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
